adder_bist_checker: RTL and testbench

//  Synthesizable response-side checker for the fourBitAdder family (FourByOne, TwoByTwo, ...).

---
 rtl/adder_bist_pkg.sv | 21 ++
 rtl/adder_golden_ref.sv | 15 +
 rtl/adder_bist_checker.sv | 110 +++++++++++
 tb/tb_adder_bist_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared types and sizing helpers for the adder BIST checker.
// Vectors are {a, b, cin}, with a in the MSBs and cin in the LSB.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    function automatic int vec_w(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int nvec(input int width);
        return 1 << vec_w(width);
    endfunction

endpackage

// File: rtl/adder_golden_ref.sv
// Golden WIDTH-bit adder: combinational {cout, s} = a + b + cin.
// Zero latency and no flow control. The block is also reusable as a reference in benches.
module adder_golden_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout
);

    assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive on-chip self-test of an external adder: sweeps every {a,b,cin} and reports pass, error count and first failure.
// Each vector takes SETTLE+2 cycles. The checker ignores start while busy and has no other backpressure.
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic [WIDTH-1:0]   o_dut_a,
    output logic [WIDTH-1:0]   o_dut_b,
    output logic               o_dut_cin,
    input  logic [WIDTH-1:0]   i_dut_s,
    input  logic               i_dut_cout,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [ERR_W-1:0]   o_err_count,
    output logic [2*WIDTH:0]   o_first_fail
);

    localparam int VEC_W = vec_w(WIDTH);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;
    localparam logic [VEC_W-1:0] IDX_LAST    = VEC_W'(nvec(WIDTH) - 1);

    state_t             r_state;
    state_t             w_next;
    logic [VEC_W-1:0]   r_idx;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   r_first_fail;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic [ERR_W-1:0]   r_err_count;
    logic [WIDTH-1:0]   w_gold_s;
    logic               w_gold_cout;
    logic               w_mismatch;

    adder_golden_ref #(.WIDTH(WIDTH)) u_golden (
        .i_a    (r_vec[VEC_W-1 -: WIDTH]),
        .i_b    (r_vec[WIDTH:1]),
        .i_cin  (r_vec[0]),
        .o_s    (w_gold_s),
        .o_cout (w_gold_cout)
    );

    assign w_mismatch = {w_gold_cout, w_gold_s} != {i_dut_cout, i_dut_s};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = S_DRIVE;
            S_DRIVE:        w_next = (SETTLE == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE:       if (r_settle_cnt == SETTLE_LAST) w_next = S_CHECK;
            S_CHECK:        w_next = (r_idx == IDX_LAST) ? S_DONE : S_DRIVE;
            default:        w_next = S_IDLE;
        endcase
    end

    // The first failure is captured only while the count is still zero, so a saturated count cannot re-arm it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx        <= '0;
            r_vec        <= '0;
            r_first_fail <= '0;
            r_settle_cnt <= '0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_idx        <= '0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
                    end
                end
                S_DRIVE: begin
                    r_vec        <= r_idx;
                    r_settle_cnt <= '0;
                end
                S_SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
                        if (r_err_count == '0) r_first_fail <= r_idx;
                    end
                    if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_dut_a      = r_vec[VEC_W-1 -: WIDTH];
    assign o_dut_b      = r_vec[WIDTH:1];
    assign o_dut_cin    = r_vec[0];
    assign o_busy       = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign o_done       = (r_state == S_DONE);
    assign o_pass       = o_done && (r_err_count == '0);
    assign o_err_count  = r_err_count;
    assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: fault-injectable adder plus a sweep-timing model compared every cycle.
module tb_adder_bist_checker;

    localparam int N   = 512;
    localparam int T   = 3;
    localparam int TOT = N * T;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start1;
    logic [3:0] a, b, s, a1, b1, s1;
    logic       cin, cout, cin1, cout1;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [7:0] err, err1;
    logic [8:0] ff, ff1;
    int         mode, seed;
    int         checks = 0;
    int         passed = 0;

    adder_bist_checker #(.WIDTH(4), .SETTLE(1), .ERR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_dut_a(a), .o_dut_b(b), .o_dut_cin(cin),
        .i_dut_s(s), .i_dut_cout(cout),
        .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_err_count(err), .o_first_fail(ff)
    );

    adder_bist_checker #(.WIDTH(4), .SETTLE(0), .ERR_W(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1),
        .o_dut_a(a1), .o_dut_b(b1), .o_dut_cin(cin1),
        .i_dut_s(s1), .i_dut_cout(cout1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_count(err1), .o_first_fail(ff1)
    );

    function automatic logic [4:0] golden(input int v);
        return 5'((v >> 5) & 15) + 5'((v >> 1) & 15) + 5'(v & 1);
    endfunction

    function automatic logic [4:0] adder_out(input int md, input int sd, input int v);
        logic [4:0] g;
        g = golden(v);
        case (md)
            1: return {1'b0, g[3:0]};
            2: return (v == 511) ? {g[4], 4'b0000} : g;
            3: return ((((v * 7) ^ sd) % 37) == 0) ? (g ^ 5'((sd % 31) + 1)) : g;
            default: return g;
        endcase
    endfunction

    always_comb {cout, s} = adder_out(mode, seed, int'({a, b, cin}));
    assign {cout1, s1} = {1'b0, a1} + {1'b0, b1} + {4'b0000, cin1};

    // Sweep model: edges since the accepted start, plus per-vector error prefix sums.
    bit m_seen = 0;
    bit m_run  = 0;
    int m_k    = 0;
    int m_prev = 0;
    int m_perr [0:N];
    int m_pff  [0:N];

    function automatic int exp_dut();
        int k;
        if (!m_run || m_k == 0) return m_prev;
        k = (m_k - 1) / T;
        return (k > N - 1) ? N - 1 : k;
    endfunction

    function automatic void build_model();
        bit mism;
        m_perr[0] = 0;
        m_pff[0]  = 0;
        for (int v = 0; v < N; v++) begin
            mism = adder_out(mode, seed, v) != golden(v);
            m_perr[v+1] = m_perr[v] + int'(mism);
            m_pff[v+1]  = (m_perr[v] == 0 && mism) ? v : m_pff[v];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_seen = 1; m_run = 0; m_k = 0; m_prev = 0;
        end else if (m_seen) begin
            if (start && (!m_run || m_k >= TOT)) begin
                m_prev = exp_dut();
                build_model();
                m_run = 1;
                m_k   = 0;
            end else if (m_run && m_k < TOT) begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        int c, e, f;
        logic eb, ed, ep;
        if (m_seen) begin
            c  = !m_run ? 0 : ((m_k >= TOT) ? N : m_k / T);
            e  = m_run ? m_perr[c] : 0;
            f  = m_run ? m_pff[c] : 0;
            e  = (e > 255) ? 255 : e;
            eb = m_run && (m_k < TOT);
            ed = m_run && (m_k >= TOT);
            ep = ed && (e == 0);
            check("cycle", {3'b0, busy, done, pass, err, ff, a, b, cin},
                  {3'b0, eb, ed, ep, 8'(e), 9'(f), 9'(exp_dut())});
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int n0, output int n);
        n = n0;
        while (!(sel ? done1 : done) && n < n0 + 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic sweep(input int md, input string name, input int xp, input int xe, input int xf);
        int n;
        mode = md;
        pulse_start();
        wait_done(1'b0, 0, n);
        check({name, "_edges"}, n, TOT);
        check({name, "_pass"}, pass, xp);
        check({name, "_err"}, err, xe);
        check({name, "_ff"}, ff, xf);
    endtask

    initial begin
        int n, r, e;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; mode = 0; seed = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_state", {busy, done, pass, err, ff, a, b, cin}, 0);

        sweep(0, "good", 1, 0, 0);
        sweep(1, "cout_stuck", 0, 255, 9'h01F);
        check("model_cout_stuck_count", m_perr[N], 256);
        sweep(2, "fff_fault", 0, 1, 9'h1FF);

        // Restart from DONE clears the previous report; a start mid-sweep is ignored.
        mode = 0;
        pulse_start();
        check("restart_clear", {busy, done, pass, err, ff}, {1'b1, 1'b0, 1'b0, 8'd0, 9'd0});
        repeat (99) @(negedge clk);
        pulse_start();
        wait_done(1'b0, 100, n);
        check("restart_edges", n, TOT);
        check("restart_pass", pass, 1);

        // A reset during a CHECK edge aborts the sweep.
        pulse_start();
        repeat (701) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_state", {busy, done, pass, err, ff, a, b, cin}, 0);
        sweep(0, "post_abort", 1, 0, 0);

        for (int i = 0; i < 3; i++) begin
            seed = $urandom_range(0, 1000);
            mode = 3;
            pulse_start();
            r = $urandom_range(2, 1400);
            repeat (r - 1) @(negedge clk);
            pulse_start();
            wait_done(1'b0, r, n);
            e = (m_perr[N] > 255) ? 255 : m_perr[N];
            check("rand_edges", n, TOT);
            check("rand_err", err, e);
            check("rand_ff", ff, m_pff[N]);
            check("rand_pass", pass, (m_perr[N] == 0) ? 1 : 0);
        end

        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b1, 0, n);
        check("settle0_edges", n, 1024);
        check("settle0_pass", pass1, 1);
        check("settle0_err", err1, 0);
        check("settle0_ff", ff1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
